// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: state encoding and
// the ID/EX payload/control field layout so every stage packs fields identically.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    // ID/EX payload layout, LSB first: SignExtend, Rd, Rt, Rs addresses, RtData, RsData.
    localparam int SEXT_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int RT_DATA_W   = 32;
    localparam int RS_DATA_W   = 32;
    localparam int SEXT_LSB    = 0;
    localparam int RD_ADDR_LSB = SEXT_LSB + SEXT_W;
    localparam int RT_ADDR_LSB = RD_ADDR_LSB + REG_ADDR_W;
    localparam int RS_ADDR_LSB = RT_ADDR_LSB + REG_ADDR_W;
    localparam int RT_DATA_LSB = RS_ADDR_LSB + REG_ADDR_W;
    localparam int RS_DATA_LSB = RT_DATA_LSB + RT_DATA_W;
    localparam int ID_EX_DATA_W = RS_DATA_LSB + RS_DATA_W;

    // Control bundle layout, LSB first: EX, M, WB.
    localparam int EX_W   = 4;
    localparam int M_W    = 2;
    localparam int WB_W   = 2;
    localparam int EX_LSB = 0;
    localparam int M_LSB  = EX_LSB + EX_W;
    localparam int WB_LSB = M_LSB + M_W;
    localparam int ID_EX_CTRL_W = WB_LSB + WB_W;

    localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, one-entry skid
// buffer, synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 111,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              emit;

    // in_ready is a flop, so acceptance never depends combinationally on out_ready.
    assign accept = in_valid & in_ready & ~flush;
    assign emit   = out_valid & out_ready;

    // NOTE: payload and skid registers are reset too; they are few flops and a
    // known value after reset keeps out_data deterministic before the first accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Any emit this cycle has already completed downstream; drop everything else.
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        main_ctrl <= in_ctrl;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        out_data  <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (emit) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        in_ready  <= 1'b0;
                        state     <= SKID;
                    end
                end
                SKID: begin
                    if (emit) begin
                        out_data  <= skid_data;
                        main_ctrl <= skid_ctrl;
                        in_ready  <= 1'b1;
                        state     <= FULL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Legacy consumers without a valid input see a NOP bubble.
    assign out_ctrl = out_valid ? main_ctrl : CTRL_W'(CTRL_NOP);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

endmodule
